// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle add/logic/compare/branch/jump ops plus a multi-cycle shifter
// (SHIFT_STEP bits per cycle), valid/busy handshake and flush. All results are registered.
module alu_iter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1,
  localparam int unsigned SW        = $clog2(XLEN),
  localparam int unsigned CtrlW     = 32 + 4 * XLEN + 5 + SW + 4 + 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [CtrlW-1:0] alu_ctrl,
  input  logic             alu_ctrl_vld,
  input  logic             flush,
  output logic             alu_busy,
  output logic [XLEN-1:0]  alu_wb_data,
  output logic [4:0]       alu_wb_rd_addr,
  output logic             alu_wb_rd_wr_en,
  output logic [XLEN-1:0]  instr_tag_out,
  output logic [31:0]      instr_out,
  output logic [XLEN-1:0]  pc_out,
  output logic             pc_load
);

  typedef enum logic [3:0] {
    OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSll, OpSrl, OpSra,
    OpSlt, OpBeq, OpBne, OpBlt, OpBge
  } alu_op_e;

  // Decoded instruction from IDU1, MSB first.
  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] instr_tag;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd_addr;
    logic [SW-1:0]   shamt;
    alu_op_e         op;
    logic            legal;
    logic            alu;
    logic            nop;
    logic            rd;
    logic            pc;
    logic            jal;
    logic            condbr;
    logic            use_imm;
    logic            shimm5;
    logic            unsign;
  } idu1_out_t;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  localparam logic [SW:0] Step = (SW + 1)'(SHIFT_STEP);

  idu1_out_t ctrl;
  assign ctrl = idu1_out_t'(alu_ctrl);

  // Single-cycle datapath
  logic            is_shift, is_sub, op_ok, taken, lt, eq;
  logic            cout, neg, ovf;
  logic [XLEN-1:0] op_a, op_b, b_inv, res, target;
  logic [XLEN:0]   sum;
  logic [SW-1:0]   shift_n;

  always_comb begin
    is_shift = ctrl.op inside {OpSll, OpSrl, OpSra};
    is_sub   = ctrl.op inside {OpSub, OpSlt, OpBeq, OpBne, OpBlt, OpBge};
    op_ok    = ctrl.legal & ctrl.alu & ~ctrl.nop;
    shift_n  = ctrl.shimm5 ? ctrl.shamt : ctrl.rs2_data[SW-1:0];

    op_a = (ctrl.jal | (ctrl.pc & (ctrl.op == OpAdd))) ? ctrl.instr_tag : ctrl.rs1_data;
    if (ctrl.jal) begin
      op_b = XLEN'(4);
    end else if (ctrl.shimm5) begin
      op_b = {{(XLEN - SW){1'b0}}, ctrl.shamt};
    end else if (ctrl.use_imm) begin
      op_b = ctrl.imm;
    end else begin
      op_b = ctrl.rs2_data;
    end

    b_inv = is_sub ? ~op_b : op_b;
    sum   = {1'b0, op_a} + {1'b0, b_inv} + (XLEN + 1)'(is_sub);
    cout  = sum[XLEN];
    neg   = sum[XLEN-1];
    ovf   = (op_a[XLEN-1] == b_inv[XLEN-1]) & (neg != op_a[XLEN-1]);
    lt    = ctrl.unsign ? ~cout : (neg ^ ovf);
    eq    = (op_a == op_b);

    case (ctrl.op)
      OpBeq:   taken = eq;
      OpBne:   taken = ~eq;
      OpBlt:   taken = lt;
      OpBge:   taken = ~lt;
      default: taken = 1'b0;
    endcase

    target = ctrl.imm + (ctrl.pc ? ctrl.instr_tag : ctrl.rs1_data);

    case (ctrl.op)
      OpAnd:                res = op_a & op_b;
      OpOr:                 res = op_a | op_b;
      OpXor:                res = op_a ^ op_b;
      OpSlt:                res = {{(XLEN - 1){1'b0}}, lt};
      // Only zero-amount shifts complete here; the value passes through unchanged.
      OpSll, OpSrl, OpSra:  res = op_a;
      default:              res = sum[XLEN-1:0];
    endcase
  end

  // Iterative shifter state
  state_e          state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  alu_op_e         p_op_q, p_op_d;
  logic [4:0]      p_rd_q, p_rd_d;
  logic            p_wr_q, p_wr_d;
  logic [XLEN-1:0] p_tag_q, p_tag_d;
  logic [31:0]     p_instr_q, p_instr_d;

  logic [SW:0]     step_k;
  logic [XLEN-1:0] acc_shifted;

  always_comb begin
    step_k      = ({1'b0, cnt_q} < Step) ? {1'b0, cnt_q} : Step;
    acc_shifted = acc_q;
    case (p_op_q)
      OpSll:   acc_shifted = acc_q << step_k;
      // Arithmetic shift keeps the MSB, so the original sign bit fills every step.
      OpSra:   acc_shifted = XLEN'($signed(acc_q) >>> step_k);
      default: acc_shifted = acc_q >> step_k;
    endcase
  end

  // Output registers
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic            wr_en_q, wr_en_d;
  logic [XLEN-1:0] tag_q, tag_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic            pc_load_q, pc_load_d;
  logic            accept;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    p_op_d    = p_op_q;
    p_rd_d    = p_rd_q;
    p_wr_d    = p_wr_q;
    p_tag_d   = p_tag_q;
    p_instr_d = p_instr_q;
    wb_data_d = wb_data_q;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    tag_d     = tag_q;
    instr_d   = instr_q;
    pc_out_d  = pc_out_q;
    pc_load_d = 1'b0;
    accept    = alu_ctrl_vld & (state_q == StIdle) & ~flush;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_shift && (shift_n != '0)) begin
            state_d   = StShift;
            acc_d     = ctrl.rs1_data;
            cnt_d     = shift_n;
            p_op_d    = ctrl.op;
            p_rd_d    = ctrl.rd_addr;
            p_wr_d    = op_ok & ctrl.rd;
            p_tag_d   = ctrl.instr_tag;
            p_instr_d = ctrl.instr;
          end else begin
            wb_data_d = res;
            rd_addr_d = ctrl.rd_addr;
            wr_en_d   = op_ok & ctrl.rd;
            tag_d     = ctrl.instr_tag;
            instr_d   = ctrl.instr;
            pc_load_d = op_ok & ~is_shift & (ctrl.jal | (ctrl.condbr & taken));
            if (pc_load_d) begin
              pc_out_d = target;
            end
          end
        end
      end
      StShift: begin
        if (flush) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          acc_d = acc_shifted;
          cnt_d = cnt_q - step_k[SW-1:0];
          if ({1'b0, cnt_q} == step_k) begin
            state_d   = StIdle;
            wb_data_d = acc_shifted;
            rd_addr_d = p_rd_q;
            wr_en_d   = p_wr_q;
            tag_d     = p_tag_q;
            instr_d   = p_instr_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      p_op_q    <= OpAdd;
      p_rd_q    <= '0;
      p_wr_q    <= 1'b0;
      p_tag_q   <= '0;
      p_instr_q <= '0;
      wb_data_q <= '0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      tag_q     <= '0;
      instr_q   <= '0;
      pc_out_q  <= '0;
      pc_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      p_op_q    <= p_op_d;
      p_rd_q    <= p_rd_d;
      p_wr_q    <= p_wr_d;
      p_tag_q   <= p_tag_d;
      p_instr_q <= p_instr_d;
      wb_data_q <= wb_data_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      tag_q     <= tag_d;
      instr_q   <= instr_d;
      pc_out_q  <= pc_out_d;
      pc_load_q <= pc_load_d;
    end
  end

  assign alu_busy        = (state_q == StShift);
  assign alu_wb_data     = wb_data_q;
  assign alu_wb_rd_addr  = rd_addr_q;
  assign alu_wb_rd_wr_en = wr_en_q;
  assign instr_tag_out   = tag_q;
  assign instr_out       = instr_q;
  assign pc_out          = pc_out_q;
  assign pc_load         = pc_load_q;

endmodule
